// File: rtl/dch.sv
// Cascadable multi-digit hex/decade down counter with wrap or one-shot expiry.
// Latency: one clock from en/load sample to dch_q update; dch_zero is combinational from dch_q.
// Backpressure: none; dch_en gates counting, load always wins over count.
module dch #(
    parameter int DIGITS = 4
) (
    input  logic                dch_clk,
    input  logic                dch_rst_n,
    input  logic                dch_en,
    input  logic                dch_sel,
    input  logic                dch_oneshot,
    input  logic                dch_load,
    input  logic [4*DIGITS-1:0] dch_load_val,
    output logic [4*DIGITS-1:0] dch_q,
    output logic                dch_zero,
    output logic                dch_borrow,
    output logic                dch_done
);

    localparam int W = 4 * DIGITS;

    typedef enum logic {
        RUN     = 1'b0,
        EXPIRED = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic           borrow_q, borrow_d;
    logic [W-1:0]   dec_val;
    logic [W-1:0]   load_clamped;
    logic [DIGITS:0] chain;
    logic [3:0]     digit_max;
    logic           wrap;

    assign digit_max = dch_sel ? 4'd9 : 4'hF;

    // Ripple borrow through the digits: a digit moves only when every lower digit was 0.
    always_comb begin
        dec_val  = cnt_q;
        chain    = '0;
        chain[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (chain[i]) begin
                if (cnt_q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = digit_max;
                    chain[i+1]        = 1'b1;
                end else begin
                    // Out-of-range decade digits (after a sel toggle) still step down by one.
                    dec_val[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
                end
            end
        end
    end

    // Borrow out of the top digit means the whole count was zero.
    assign wrap = chain[DIGITS];

    // In decade mode, clamp any loaded digit above 9 to 9.
    always_comb begin
        load_clamped = dch_load_val;
        for (int i = 0; i < DIGITS; i++) begin
            if (dch_sel && (dch_load_val[4*i +: 4] > 4'd9)) begin
                load_clamped[4*i +: 4] = 4'd9;
            end
        end
    end

    // Next-state: load beats count; one-shot expiry freezes the count until reload.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        borrow_d = 1'b0;
        if (dch_load) begin
            cnt_d   = load_clamped;
            state_d = RUN;
        end else if (dch_en && (state_q == RUN)) begin
            if (dch_oneshot) begin
                if (wrap) begin
                    // Decrement requested at zero: expire without wrapping.
                    state_d = EXPIRED;
                end else begin
                    cnt_d = dec_val;
                    if (dec_val == '0) begin
                        state_d = EXPIRED;
                    end
                end
            end else begin
                cnt_d    = dec_val;
                borrow_d = wrap;
            end
        end
    end

    // State, count and borrow registers.
    always_ff @(posedge dch_clk or negedge dch_rst_n) begin
        if (!dch_rst_n) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
        end
    end

    assign dch_q      = cnt_q;
    assign dch_zero   = (cnt_q == '0);
    assign dch_borrow = borrow_q;
    assign dch_done   = (state_q == EXPIRED);

endmodule

// File: tb/tb_dch.sv
// Directed bench for dch with DIGITS=2: reset, decade/hex wrap, one-shot, load priority, clamp.
// Inputs driven 1 time unit after the rising edge; outputs checked at the same point.
// Summary line reports error and check counts.
module tb_dch;

    logic       dch_clk;
    logic       dch_rst_n;
    logic       dch_en;
    logic       dch_sel;
    logic       dch_oneshot;
    logic       dch_load;
    logic [7:0] dch_load_val;
    logic [7:0] dch_q;
    logic       dch_zero;
    logic       dch_borrow;
    logic       dch_done;

    int errors = 0;
    int checks = 0;

    dch #(.DIGITS(2)) dut (
        .dch_clk      (dch_clk),
        .dch_rst_n    (dch_rst_n),
        .dch_en       (dch_en),
        .dch_sel      (dch_sel),
        .dch_oneshot  (dch_oneshot),
        .dch_load     (dch_load),
        .dch_load_val (dch_load_val),
        .dch_q        (dch_q),
        .dch_zero     (dch_zero),
        .dch_borrow   (dch_borrow),
        .dch_done     (dch_done)
    );

    initial dch_clk = 1'b0;
    always #5 dch_clk = ~dch_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge dch_clk);
        #1;
    endtask

    logic [7:0] exp2 [12];
    logic [7:0] exp4 [6];
    logic       done4 [6];

    initial begin
        exp2  = '{8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04,
                  8'h03, 8'h02, 8'h01, 8'h00, 8'h99, 8'h98};
        exp4  = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        done4 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        dch_rst_n    = 1'b0;
        dch_en       = 1'b0;
        dch_sel      = 1'b0;
        dch_oneshot  = 1'b0;
        dch_load     = 1'b0;
        dch_load_val = 8'h00;

        // Reset state
        #12;
        chk("rst_q", dch_q, 8'h00);
        chk("rst_zero", dch_zero, 1'b1);
        chk("rst_done", dch_done, 1'b0);
        chk("rst_borrow", dch_borrow, 1'b0);
        dch_rst_n = 1'b1;
        step();

        // Decade wrap from 0x10
        dch_sel      = 1'b1;
        dch_oneshot  = 1'b0;
        dch_load     = 1'b1;
        dch_load_val = 8'h10;
        step();
        dch_load = 1'b0;
        chk("dec_load_q", dch_q, 8'h10);
        dch_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("dec_q[%0d]", i), dch_q, exp2[i]);
            chk($sformatf("dec_borrow[%0d]", i), dch_borrow, (i == 10) ? 1'b1 : 1'b0);
            chk($sformatf("dec_zero[%0d]", i), dch_zero, (i == 9) ? 1'b1 : 1'b0);
        end
        dch_en = 1'b0;
        step();
        chk("dec_hold_q", dch_q, 8'h98);

        // Hex wrap from 0x01
        dch_sel      = 1'b0;
        dch_load     = 1'b1;
        dch_load_val = 8'h01;
        step();
        dch_load = 1'b0;
        dch_en   = 1'b1;
        step();
        chk("hex_q0", dch_q, 8'h00);
        chk("hex_zero0", dch_zero, 1'b1);
        chk("hex_borrow0", dch_borrow, 1'b0);
        step();
        chk("hex_q1", dch_q, 8'hFF);
        chk("hex_borrow1", dch_borrow, 1'b1);
        step();
        chk("hex_q2", dch_q, 8'hFE);
        chk("hex_borrow2", dch_borrow, 1'b0);
        dch_en = 1'b0;

        // One-shot expiry
        dch_oneshot  = 1'b1;
        dch_load     = 1'b1;
        dch_load_val = 8'h03;
        step();
        dch_load = 1'b0;
        dch_en   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("os_q[%0d]", i), dch_q, exp4[i]);
            chk($sformatf("os_done[%0d]", i), dch_done, done4[i]);
            chk($sformatf("os_borrow[%0d]", i), dch_borrow, 1'b0);
        end
        // Leaving one-shot mode does not release EXPIRED
        dch_oneshot = 1'b0;
        step();
        chk("os_off_q", dch_q, 8'h00);
        chk("os_off_done", dch_done, 1'b1);
        chk("os_off_borrow", dch_borrow, 1'b0);
        dch_load     = 1'b1;
        dch_load_val = 8'h05;
        step();
        chk("os_reload_q", dch_q, 8'h05);
        chk("os_reload_done", dch_done, 1'b0);
        dch_load = 1'b0;
        step();
        chk("os_resume_q", dch_q, 8'h04);

        // Load overrides count
        dch_sel      = 1'b0;
        dch_load     = 1'b1;
        dch_load_val = 8'h21;
        step();
        dch_load = 1'b0;
        step();
        chk("lvc_q20", dch_q, 8'h20);
        dch_load     = 1'b1;
        dch_load_val = 8'h42;
        step();
        chk("lvc_q42", dch_q, 8'h42);
        dch_load = 1'b0;
        step();
        chk("lvc_q41", dch_q, 8'h41);
        dch_en = 1'b0;

        // Clamp and sel switch
        dch_sel      = 1'b1;
        dch_load     = 1'b1;
        dch_load_val = 8'hAF;
        step();
        chk("clamp_q", dch_q, 8'h99);
        dch_sel      = 1'b0;
        dch_load_val = 8'hA0;
        step();
        chk("noclamp_q", dch_q, 8'hA0);
        dch_load = 1'b0;
        dch_sel  = 1'b1;
        dch_en   = 1'b1;
        step();
        chk("selsw_q", dch_q, 8'h99);
        chk("selsw_borrow", dch_borrow, 1'b0);
        dch_en = 1'b0;

        // Async reset mid-cycle while counting
        dch_sel      = 1'b0;
        dch_load     = 1'b1;
        dch_load_val = 8'h38;
        dch_en       = 1'b1;
        step();
        dch_load = 1'b0;
        step();
        chk("ar_pre_q", dch_q, 8'h37);
        #2;
        dch_rst_n = 1'b0;
        #1;
        chk("ar_q", dch_q, 8'h00);
        chk("ar_zero", dch_zero, 1'b1);
        chk("ar_done", dch_done, 1'b0);
        #6;
        dch_rst_n = 1'b1;
        step();
        chk("ar_after_q", dch_q, 8'hFF);
        chk("ar_after_borrow", dch_borrow, 1'b1);
        dch_en = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
